// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer for the 4-bit computer: latches instructions, runs the
// source-mux + immediate adder, and writes back A/B/out_port/carry/PC under control-word loads.
module cpu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [3:0] pc,
  input  logic [7:0] instr,
  output logic [3:0] opcode,
  input  logic [9:0] ctrl,
  input  logic [3:0] in_port,
  output logic [3:0] out_port,
  output logic [3:0] reg_a,
  output logic [3:0] reg_b,
  output logic       carry,
  output logic       fetch
);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] out_q, out_d;
  logic       carry_q, carry_d;

  logic [3:0] src;
  logic [4:0] sum;
  logic       jump_taken;

  always_comb begin
    unique case (ctrl[1:0])
      2'b00:   src = a_q;
      2'b01:   src = b_q;
      2'b10:   src = in_port;
      default: src = 4'd0;
    endcase
    sum = {1'b0, src} + {1'b0, ir_q[3:0]};
    // Conditional jump looks at the carry left by the previous instruction.
    jump_taken = ctrl[5] && (!ctrl[6] || !carry_q);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = carry_q;
    if (en) begin
      unique case (state_q)
        ST_FETCH: begin
          ir_d    = instr;
          state_d = ST_EXEC;
        end
        ST_EXEC: begin
          if (ctrl[2]) a_d   = sum[3:0];
          if (ctrl[3]) b_d   = sum[3:0];
          if (ctrl[4]) out_d = sum[3:0];
          carry_d = sum[4];
          pc_d    = jump_taken ? sum[3:0] : pc_q + 4'd1;
          state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= 4'd0;
      ir_q    <= 8'd0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      out_q   <= 4'd0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  assign pc       = pc_q;
  assign opcode   = ir_q[7:4];
  assign out_port = out_q;
  assign reg_a    = a_q;
  assign reg_b    = b_q;
  assign carry    = carry_q;
  assign fetch    = (state_q == ST_FETCH);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed program snippets plus randomized cycles, all
// compared against an instruction-level reference model.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] pc, opcode, in_port, out_port, reg_a, reg_b;
  logic [7:0] instr;
  logic [9:0] ctrl;
  logic       carry, fetch;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: architectural registers plus which half of the instruction is next.
  int m_pc, m_ir, m_a, m_b, m_out, m_c;
  bit m_exec;

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .instr(instr), .opcode(opcode),
    .ctrl(ctrl), .in_port(in_port), .out_port(out_port), .reg_a(reg_a),
    .reg_b(reg_b), .carry(carry), .fetch(fetch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input int i, input int c, input int ip);
    int src, s, res;
    bit take;
    if (r) begin
      m_pc = 0; m_ir = 0; m_a = 0; m_b = 0; m_out = 0; m_c = 0; m_exec = 0;
    end else if (e) begin
      if (!m_exec) begin
        m_ir   = i;
        m_exec = 1;
      end else begin
        case (c % 4)
          0: src = m_a;
          1: src = m_b;
          2: src = ip;
          default: src = 0;
        endcase
        s    = src + (m_ir % 16);
        res  = s % 16;
        take = ((c >> 5) & 1) == 1 && (((c >> 6) & 1) == 0 || m_c == 0);
        if ((c >> 2) & 1) m_a = res;
        if ((c >> 3) & 1) m_b = res;
        if ((c >> 4) & 1) m_out = res;
        m_pc   = take ? res : (m_pc + 1) % 16;
        m_c    = (s > 15) ? 1 : 0;
        m_exec = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("opcode", opcode, m_ir / 16);
    chk("reg_a", reg_a, m_a);
    chk("reg_b", reg_b, m_b);
    chk("out_port", out_port, m_out);
    chk("carry", carry, m_c);
    chk("fetch", fetch, m_exec ? 0 : 1);
  endtask

  task automatic step(input bit r, input bit e, input logic [7:0] i,
                      input logic [9:0] c, input logic [3:0] ip);
    rst = r; en = e; instr = i; ctrl = c; in_port = ip;
    @(posedge clk);
    model_edge(r, e, int'(i), int'(c), int'(ip));
    #1;
    check_all();
  endtask

  // One whole instruction: enabled FETCH then enabled EXEC.
  task automatic run_instr(input logic [7:0] i, input logic [9:0] c, input logic [3:0] ip);
    step(0, 1, i, 10'h000, 4'h0);
    step(0, 1, 8'h00, c, ip);
  endtask

  initial begin
    rst = 1; en = 0; instr = 0; ctrl = 0; in_port = 0;
    step(1, 0, 8'h00, 10'h000, 4'h0);
    chk("rst_pc", pc, 0);
    chk("rst_fetch", fetch, 1);

    // Load immediate then add with overflow.
    run_instr(8'h35, 10'h007, 4'h0);
    chk("li_a", reg_a, 5); chk("li_c", carry, 0); chk("li_pc", pc, 1);
    run_instr(8'h0C, 10'h004, 4'h0);
    chk("add_a", reg_a, 1); chk("add_c", carry, 1); chk("add_pc", pc, 2);

    // Conditional jump: not taken with carry set, taken on repeat.
    run_instr(8'hE9, 10'h063, 4'h0);
    chk("jnc1_pc", pc, 3); chk("jnc1_c", carry, 0);
    run_instr(8'hE9, 10'h063, 4'h0);
    chk("jnc2_pc", pc, 9); chk("jnc2_c", carry, 0);

    // Input to output port.
    run_instr(8'h43, 10'h012, 4'hA);
    chk("io_out", out_port, 4'hD); chk("io_c", carry, 0);
    chk("io_a", reg_a, 1); chk("io_b", reg_b, 0);

    // Jump to 15, then NOP wraps PC.
    run_instr(8'h0F, 10'h023, 4'h0);
    chk("j15_pc", pc, 15);
    run_instr(8'h00, 10'h000, 4'h0);
    chk("wrap_pc", pc, 0);

    // Hold mid-EXEC, then resume.
    step(0, 1, 8'h21, 10'h000, 4'h0);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 8'hFF, 10'h01F, 4'hF);
      chk("hold_fetch", fetch, 0);
    end
    step(0, 1, 8'h00, 10'h007, 4'h0);
    chk("resume_a", reg_a, 1); chk("resume_pc", pc, 1);

    // Reset landing on the EXEC edge of a load.
    step(1, 0, 8'h00, 10'h000, 4'h0);
    step(0, 1, 8'h37, 10'h000, 4'h0);
    step(1, 1, 8'h00, 10'h007, 4'h0);
    chk("rstx_a", reg_a, 0); chk("rstx_pc", pc, 0); chk("rstx_fetch", fetch, 1);

    // Randomized cycles with occasional reset and stalls.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           8'($urandom), 10'($urandom), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
